// File: rtl/wb_pipe_mem.sv
// Wishbone B4 pipelined SRAM slave; in-range -> ack_o, out-of-range -> err_o, READ_LAT (1|2) cycles after accept.
// No internal backpressure (stall_o=0) unless WBMEM_STALL_INJECT_EN adds LFSR-driven stalls; cyc_i drop aborts in-flight responses.
module wb_pipe_mem #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32,
  parameter int READ_LAT    = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   adr_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic                stb_i,
  input  logic                cyc_i,
  output logic                stall_o,
  output logic                ack_o,
  output logic                err_o,
  output logic [DATA_W-1:0]   dat_o
);
  localparam int NB     = DATA_W / 8;
  localparam int OFF    = $clog2(NB);
  localparam int IDX_W  = ADDR_W - OFF;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic              is_read;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic [IDX_W-1:0]  word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;
  logic              acc;
  rsp_t              new_rsp;
  rsp_t              tail_in;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic              resp_vld_d, resp_vld_q;
  logic              resp_err_d, resp_err_q;
  logic [DATA_W-1:0] dat_d, dat_q;

  assign word_idx = adr_i[ADDR_W-1:OFF];
  assign mem_idx  = word_idx[MEM_AW-1:0];
  // Full-width compare so high address bits never alias into the array.
  assign in_range = ({1'b0, word_idx} < (IDX_W+1)'(DEPTH_WORDS));
  assign acc      = cyc_i & stb_i & ~stall_o & ~rst_i;

  if (OFF > 0) begin : g_lsb
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^adr_i[OFF-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (acc && we_i && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_i[b]) mem_q[mem_idx][b*8 +: 8] <= dat_i[b*8 +: 8];
      end
    end
  end

  always_comb begin
    new_rsp         = '0;
    new_rsp.vld     = acc;
    new_rsp.err     = ~in_range;
    new_rsp.is_read = ~we_i;
    if (in_range && !we_i) new_rsp.data = mem_q[mem_idx];
  end

  if (READ_LAT == 2) begin : g_lat2
    rsp_t mid_d, mid_q;

    always_comb begin
      mid_d   = new_rsp;
      tail_in = cyc_i ? mid_q : '0;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) mid_q <= '0;
      else       mid_q <= mid_d;
    end
  end else if (READ_LAT == 1) begin : g_lat1
    assign tail_in = new_rsp;
  end else begin : g_bad_lat
    $error("wb_pipe_mem: READ_LAT must be 1 or 2");
    assign tail_in = '0;
  end

  // dat_o only moves on an in-range read so write acks and errors never disturb it.
  always_comb begin
    resp_vld_d = tail_in.vld;
    resp_err_d = tail_in.err;
    dat_d      = dat_q;
    if (tail_in.vld && tail_in.is_read && !tail_in.err) dat_d = tail_in.data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_vld_q <= 1'b0;
      resp_err_q <= 1'b0;
      dat_q      <= '0;
    end else begin
      resp_vld_q <= resp_vld_d;
      resp_err_q <= resp_err_d;
      dat_q      <= dat_d;
    end
  end

  assign ack_o = resp_vld_q & ~resp_err_q & cyc_i;
  assign err_o = resp_vld_q &  resp_err_q & cyc_i;
  assign dat_o = dat_q;

`ifdef WBMEM_STALL_INJECT_EN
  logic [15:0] lfsr_d, lfsr_q;
  logic        stall_d, stall_q;

  // Right-shift Galois form of x^16+x^14+x^13+x^11+1.
  always_comb begin
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    stall_d = lfsr_q[1] & lfsr_q[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q  <= 16'hACE1;
      stall_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      stall_q <= stall_d;
    end
  end

  assign stall_o = stall_q;
`else
  assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_pipe_mem.sv
// Directed bench for wb_pipe_mem: READ_LAT=1 and READ_LAT=2 instances share one request stream
// and are checked against hand-computed values and a small memory model.
module tb_wb_pipe_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic        we  = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] dat = '0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        stall1, ack1, err1, stall2, ack2, err2;
  logic [31:0] dat_o1, dat_o2;

  always #5 clk = ~clk;

  wb_pipe_mem #(.DATA_W(32), .DEPTH_WORDS(1024), .ADDR_W(32), .READ_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .we_i(we), .sel_i(sel), .dat_i(dat),
    .stb_i(stb), .cyc_i(cyc), .stall_o(stall1), .ack_o(ack1), .err_o(err1), .dat_o(dat_o1));

  wb_pipe_mem #(.DATA_W(32), .DEPTH_WORDS(1024), .ADDR_W(32), .READ_LAT(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .we_i(we), .sel_i(sel), .dat_i(dat),
    .stb_i(stb), .cyc_i(cyc), .stall_o(stall2), .ack_o(ack2), .err_o(err2), .dat_o(dat_o2));

  typedef struct packed { logic err; logic [31:0] dat; logic [31:0] cyc; } rsp_rec_t;
  typedef struct packed { logic err; logic rd; logic [31:0] dat; } exp_t;

  int          total = 0;
  int          bad = 0;
  int          cyc_cnt = 0;
  int          both_cnt = 0;
  int          mon_cyc = 0;
  int          mon_stall = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_dat = '0;
  logic [31:0] model [1024] = '{default: '0};
  rsp_rec_t    mq1[$], mq2[$];
  exp_t        expq[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if ((ack1 && err1) || (ack2 && err2)) both_cnt++;
    if (mon_en) begin
      mon_cyc++;
      if (stall1) mon_stall++;
      if (ack1 || err1) mq1.push_back('{err: err1, dat: dat_o1, cyc: 32'(cyc_cnt)});
      if (ack2 || err2) mq2.push_back('{err: err2, dat: dat_o2, cyc: 32'(cyc_cnt)});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void mwrite(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    if ((a >> 2) < 1024) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[a[11:2]][b*8 +: 8] = d[b*8 +: 8];
    end
  endfunction

  // Presents a request and holds it until accepted; returns the accepting cycle number.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output int k);
    int n;
    n = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    @(negedge clk);
    while (stall1 && n < 64) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(stall1), 32'd0);
    k = cyc_cnt;
    tick();
  endtask

  task automatic single(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp_rd);
    logic        e;
    logic [31:0] exp_dat;
    int          k;
    e       = ((a >> 2) >= 1024);
    exp_dat = (!w && !e) ? exp_rd : last_dat;
    issue(w, a, s, d, k);
    stb = 1'b0; we = 1'b0;
    if (w) mwrite(a, s, d);
    @(negedge clk);
    check("rl1_ack", 32'(ack1), 32'(!e));
    check("rl1_err", 32'(err1), 32'(e));
    check("rl1_dat", dat_o1, exp_dat);
    check("rl2_early", 32'({ack2, err2}), 32'd0);
    tick();
    @(negedge clk);
    check("rl1_quiet", 32'({ack1, err1}), 32'd0);
    check("rl2_ack", 32'(ack2), 32'(!e));
    check("rl2_err", 32'(err2), 32'(e));
    check("rl2_dat", dat_o2, exp_dat);
    last_dat = exp_dat;
    tick();
  endtask

  task automatic do_reset;
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = 32'h20; sel = 4'hF; dat = 32'hFFFF_FFFF;
    repeat (3) tick();
    rst = 1'b0; stb = 1'b0; we = 1'b0;
    last_dat = '0;
  endtask

  // Runs from the first cycle after reset release: outputs idle, stall sequence reproducible.
  task automatic post_reset_chk;
    logic exp_stall;
`ifdef WBMEM_STALL_INJECT_EN
    logic [15:0] m;
    m = 16'hACE1;
`endif
    @(negedge clk);
    check("rst_stall", 32'(stall1), 32'd0);
    check("rst_ack_err", 32'({ack1, err1, ack2, err2}), 32'd0);
    check("rst_dat1", dat_o1, 32'd0);
    check("rst_dat2", dat_o2, 32'd0);
    for (int j = 0; j < 24; j++) begin
      tick();
      @(negedge clk);
`ifdef WBMEM_STALL_INJECT_EN
      exp_stall = m[1] & m[0];
      m = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
`else
      exp_stall = 1'b0;
`endif
      check("stall_seq", 32'(stall1), 32'(exp_stall));
      check("idle_ack_err", 32'({ack1, err1, ack2, err2}), 32'd0);
      check("idle_dat", dat_o1 | dat_o2, 32'd0);
    end
    tick();
  endtask

  task automatic burst_rd(input int n);
    int acc[$];
    int k;
    mq1.delete(); mq2.delete();
    mon_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      issue(1'b0, 32'(i * 4), 4'hF, 32'd0, k);
      acc.push_back(k);
    end
    stb = 1'b0;
    repeat (4) tick();
    mon_en = 1'b0;
    check("burst_cnt1", 32'(mq1.size()), 32'(n));
    check("burst_cnt2", 32'(mq2.size()), 32'(n));
    for (int i = 0; i < n && i < mq1.size() && i < mq2.size(); i++) begin
      check("burst_err", 32'({mq1[i].err, mq2[i].err}), 32'd0);
      check("burst_dat1", mq1[i].dat, 32'(i));
      check("burst_dat2", mq2[i].dat, 32'(i));
      check("burst_lat1", mq1[i].cyc, 32'(acc[i] + 1));
      check("burst_lat2", mq2[i].cyc, 32'(acc[i] + 2));
    end
    last_dat = 32'(n - 1);
  endtask

  initial begin
    int k0, k1, k2, k3, drop, late, exp1, exp2, pct, stall0, cyc0;
    int acc4[4];

    // Reset with a write request held on the bus; it must not land.
    do_reset();
    post_reset_chk();

    single(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'd0);
    single(1'b1, 32'h10, 4'h1, 32'h0000_00AA, 32'd0);
    single(1'b0, 32'h10, 4'hF, 32'd0, 32'hDEAD_BEAA);
    single(1'b0, 32'h20, 4'hF, 32'd0, 32'h0000_0000);
    single(1'b1, 32'h14, 4'h0, 32'hFFFF_FFFF, 32'd0);
    single(1'b0, 32'h14, 4'hF, 32'd0, 32'h0000_0000);
    single(1'b1, 32'h18, 4'hA, 32'h1122_3344, 32'd0);
    single(1'b0, 32'h18, 4'hF, 32'd0, 32'h1100_3300);
    single(1'b0, 32'h13, 4'hF, 32'd0, 32'hDEAD_BEAA);

    // Out of range: error, dat_o held, no aliasing into low words.
    single(1'b0, 32'h1000, 4'hF, 32'd0, 32'd0);
    single(1'b1, 32'h1000, 4'hF, 32'h1234_5678, 32'd0);
    single(1'b0, 32'h0, 4'hF, 32'd0, 32'h0000_0000);
    single(1'b1, 32'h0040_1010, 4'hF, 32'h5555_5555, 32'd0);
    single(1'b0, 32'h10, 4'hF, 32'd0, 32'hDEAD_BEAA);
    single(1'b0, 32'hFFFF_FFF0, 4'hF, 32'd0, 32'd0);

    for (int i = 0; i < 8; i++) single(1'b1, 32'(i * 4), 4'hF, 32'(i), 32'd0);
    burst_rd(8);

    // Abort: write + 3 reads back to back, then cyc_i drops.
    mq1.delete(); mq2.delete();
    mon_en = 1'b1;
    issue(1'b1, 32'h100, 4'hF, 32'hCAFE_F00D, k0);
    mwrite(32'h100, 4'hF, 32'hCAFE_F00D);
    issue(1'b0, 32'h0, 4'hF, 32'd0, k1);
    issue(1'b0, 32'h4, 4'hF, 32'd0, k2);
    issue(1'b0, 32'h8, 4'hF, 32'd0, k3);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    drop = cyc_cnt;
    repeat (4) tick();
    mon_en = 1'b0;
    acc4 = '{k0, k1, k2, k3};
    exp1 = 0; exp2 = 0;
    for (int i = 0; i < 4; i++) begin
      if (acc4[i] + 1 < drop) exp1++;
      if (acc4[i] + 2 < drop) exp2++;
    end
    late = 0;
    foreach (mq1[i]) if (mq1[i].cyc >= 32'(drop)) late++;
    foreach (mq2[i]) if (mq2[i].cyc >= 32'(drop)) late++;
    check("abort_late_rsp", 32'(late), 32'd0);
    check("abort_cnt1", 32'(mq1.size()), 32'(exp1));
    check("abort_cnt2", 32'(mq2.size()), 32'(exp2));
    for (int i = 1; i < mq2.size(); i++) check("abort_dat2", mq2[i].dat, 32'(i - 1));
    single(1'b0, 32'h100, 4'hF, 32'd0, 32'hCAFE_F00D);

    // Reset in the middle of a burst discards in-flight responses.
    issue(1'b0, 32'h100, 4'hF, 32'd0, k0);
    issue(1'b0, 32'h4, 4'hF, 32'd0, k1);
    rst = 1'b1; stb = 1'b0;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("midrst_ack_err", 32'({ack1, err1, ack2, err2}), 32'd0);
      check("midrst_dat", dat_o1 | dat_o2, 32'd0);
      tick();
    end

    // Fresh reset: stall sequence must repeat, then a mixed random run against the model.
    do_reset();
    post_reset_chk();
    mq1.delete(); mq2.delete(); expq.delete();
    cyc0 = mon_cyc; stall0 = mon_stall;
    mon_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic        w;
      logic [31:0] a, d;
      logic [3:0]  s;
      exp_t        e;
      int          k;
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 15));
      else                           a = 32'($urandom_range(0, 63));
      s = 4'($urandom);
      d = $urandom;
      e.err = ((a >> 2) >= 1024);
      e.rd  = !w;
      e.dat = e.err ? 32'd0 : model[a[11:2]];
      expq.push_back(e);
      if (w) mwrite(a, s, d);
      issue(w, a, s, d, k);
      stb = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    repeat (4) tick();
    mon_en = 1'b0;
    cyc = 1'b0;
    check("rand_cnt1", 32'(mq1.size()), 32'(expq.size()));
    check("rand_cnt2", 32'(mq2.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < mq1.size()) begin
        check("rand_err1", 32'(mq1[i].err), 32'(expq[i].err));
        if (expq[i].rd && !expq[i].err) check("rand_dat1", mq1[i].dat, expq[i].dat);
      end
      if (i < mq2.size()) begin
        check("rand_err2", 32'(mq2[i].err), 32'(expq[i].err));
        if (expq[i].rd && !expq[i].err) check("rand_dat2", mq2[i].dat, expq[i].dat);
      end
    end
    pct = ((mon_stall - stall0) * 100) / (mon_cyc - cyc0);
`ifdef WBMEM_STALL_INJECT_EN
    check("stall_duty_ok", 32'(pct >= 15 && pct <= 35), 32'd1);
`else
    check("stall_duty", 32'(pct), 32'd0);
`endif
    check("ack_err_both", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
